cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control_pkg.sv | 56 +++++
 rtl/cpu_control_mem_watchdog.sv | 32 +++
 rtl/cpu_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_cpu_control.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pkg.sv
// lc3b_types: shared types for the LC-3b control path.
//   lc3b_opcode     - 4-bit IR opcode field
//   lc3b_aluop      - ALU operation select
//   lc3b_ctrl_state - control FSM state encoding; the HALT state exists only
//                     when CPU_CONTROL_MEM_TIMEOUT_EN is defined.
//   is_mem_state()  - true for states that hold a memory request open.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef enum logic [4:0] {
        s_fetch1, s_fetch2, s_fetch3, s_decode,
        s_add, s_and, s_not, s_shf,
        s_br, s_br_taken, s_jmp, s_jsr, s_jsr_pc, s_lea,
        s_calc_addr, s_calc_baddr,
        s_ld_mem, s_ld_wb, s_ldb_wb,
        s_ind_mem, s_ind_mar,
        s_st_mdr,
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
        s_halt,
`endif
        s_st_mem
    } lc3b_ctrl_state;

    function automatic logic is_mem_state(input lc3b_ctrl_state s);
        return (s == s_fetch2) || (s == s_ld_mem) || (s == s_ind_mem) || (s == s_st_mem);
    endfunction

endpackage

// File: rtl/cpu_control_mem_watchdog.sv
// mem_watchdog: counts memory-wait cycles and flags when the limit is hit.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at zero (FSM is not in a memory state)
//   tick       : one more wait cycle (memory state, mem_resp low)
//   limit      : wait-cycle limit, 1..255
//   expired    : this tick is the limit-th consecutive wait cycle
module mem_watchdog (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick && (count != 8'hff)) begin
            count <= count + 8'd1;
        end
    end

    // Flag in the cycle that would make the count reach the limit, so the
    // FSM leaves on the very next edge.
    assign expired = tick && !clear && (({1'b0, count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/cpu_control.sv
// cpu_control: Moore control FSM for the LC-3b multicycle datapath.
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, *_enable,
//   d_bit, a_bit      : IR fields and branch condition from the datapath
//   mar_lsb           : byte select for LDB/STB
//   mem_resp          : memory handshake done (may come in the request cycle)
//   load_* / *_sel    : datapath register loads and mux selects
//   aluop             : ALU operation
//   mem_read/write    : memory strobes, mem_byte_enable lane mask
//   mem_error         : sticky memory-timeout fault
// Build option: define CPU_CONTROL_MEM_TIMEOUT_EN to add a memory-wait
// watchdog (limit MEM_TIMEOUT) that parks the FSM in HALT until reset.
module cpu_control
    import lc3b_types::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_opcode opcode,
    input  logic       branch_enable,
    input  logic       imm5_enable,
    input  logic       offset11_enable,
    input  logic       d_bit,
    input  logic       a_bit,
    input  logic       mar_lsb,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic [1:0] pcmux_sel,
    output logic [1:0] alumux_sel,
    output logic [1:0] regfilemux_sel,
    output logic [1:0] marmux_sel,
    output logic [1:0] loadmux_sel,
    output logic       storemux_sel,
    output logic       mdrmux_sel,
    output logic       pcoffsetmux_sel,
    output logic       maradjmux_sel,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output logic       mem_error
);

    if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
        $error("cpu_control: MEM_TIMEOUT must be in 1..255");
    end

    lc3b_ctrl_state state, next_state;

`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
    logic wd_expired;

    mem_watchdog u_mem_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!is_mem_state(state)),
        .tick    (is_mem_state(state) && !mem_resp),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (wd_expired)
    );
`endif

    // NOTE: state is a flop, so it takes a non-blocking assignment; blocking
    // here would let other clocked readers see the new value in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= s_fetch1;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            s_fetch1: next_state = s_fetch2;
            s_fetch2: if (mem_resp) next_state = s_fetch3;
            s_fetch3: next_state = s_decode;
            s_decode: begin
                case (opcode)
                    op_add:                        next_state = s_add;
                    op_and:                        next_state = s_and;
                    op_not:                        next_state = s_not;
                    op_shf:                        next_state = s_shf;
                    op_br:                         next_state = s_br;
                    op_jmp:                        next_state = s_jmp;
                    op_jsr:                        next_state = s_jsr;
                    op_lea:                        next_state = s_lea;
                    op_ldr, op_str, op_ldi, op_sti: next_state = s_calc_addr;
                    op_ldb, op_stb:                next_state = s_calc_baddr;
                    default:                       next_state = s_fetch1;
                endcase
            end
            s_br:         next_state = branch_enable ? s_br_taken : s_fetch1;
            s_jsr:        next_state = s_jsr_pc;
            s_calc_addr: begin
                case (opcode)
                    op_ldr:         next_state = s_ld_mem;
                    op_str:         next_state = s_st_mdr;
                    op_ldi, op_sti: next_state = s_ind_mem;
                    default:        next_state = s_fetch1;
                endcase
            end
            s_calc_baddr: next_state = (opcode == op_stb) ? s_st_mdr : s_ld_mem;
            s_ind_mem:    if (mem_resp) next_state = s_ind_mar;
            s_ind_mar:    next_state = (opcode == op_sti) ? s_st_mdr : s_ld_mem;
            s_ld_mem:     if (mem_resp) next_state = (opcode == op_ldb) ? s_ldb_wb : s_ld_wb;
            s_st_mdr:     next_state = s_st_mem;
            s_st_mem:     if (mem_resp) next_state = s_fetch1;
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
            s_halt:       next_state = s_halt;
`endif
            default:      next_state = s_fetch1;
        endcase
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
        // Only raised while waiting with mem_resp low, so it never races a completion.
        if (wd_expired) next_state = s_halt;
`endif
    end

    // Outputs decode the state directly; gating on rst_n keeps every strobe
    // quiet during reset even though FETCH1 is the reset state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned, which would infer a latch.
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 2'b00;
        alumux_sel      = 2'b00;
        regfilemux_sel  = 2'b00;
        marmux_sel      = 2'b00;
        loadmux_sel     = 2'b00;
        storemux_sel    = 1'b0;
        mdrmux_sel      = 1'b0;
        pcoffsetmux_sel = 1'b0;
        maradjmux_sel   = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        mem_error       = 1'b0;
        if (rst_n) begin
            case (state)
                s_fetch1: begin
                    load_mar   = 1'b1;
                    marmux_sel = 2'b01;
                    load_pc    = 1'b1;
                end
                s_fetch2, s_ind_mem, s_ld_mem: begin
                    mem_read   = 1'b1;
                    load_mdr   = 1'b1;
                    mdrmux_sel = 1'b1;
                end
                s_fetch3: load_ir = 1'b1;
                s_add, s_and, s_not: begin
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    alumux_sel   = imm5_enable ? 2'b10 : 2'b00;
                    aluop        = (state == s_add) ? alu_add :
                                   (state == s_and) ? alu_and : alu_not;
                end
                s_shf: begin
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    alumux_sel   = 2'b11;
                    aluop        = !d_bit ? alu_sll : (a_bit ? alu_sra : alu_srl);
                end
                s_br_taken: begin
                    load_pc   = 1'b1;
                    pcmux_sel = 2'b01;
                end
                s_jmp: begin
                    load_pc   = 1'b1;
                    pcmux_sel = 2'b10;
                end
                s_jsr: begin
                    load_regfile   = 1'b1;
                    regfilemux_sel = 2'b11;
                end
                s_jsr_pc: begin
                    load_pc         = 1'b1;
                    pcmux_sel       = offset11_enable ? 2'b01 : 2'b10;
                    pcoffsetmux_sel = offset11_enable;
                end
                s_lea: begin
                    // The load mux reaches the register file through regfilemux 10.
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    regfilemux_sel = 2'b10;
                    loadmux_sel    = 2'b10;
                end
                s_calc_addr: begin
                    load_mar   = 1'b1;
                    alumux_sel = 2'b01;
                    aluop      = alu_add;
                end
                s_calc_baddr: begin
                    load_mar      = 1'b1;
                    marmux_sel    = 2'b11;
                    maradjmux_sel = 1'b1;
                end
                s_ld_wb: begin
                    load_regfile   = 1'b1;
                    regfilemux_sel = 2'b01;
                    load_cc        = 1'b1;
                end
                s_ldb_wb: begin
                    load_regfile   = 1'b1;
                    regfilemux_sel = 2'b10;
                    loadmux_sel    = {1'b0, mar_lsb};
                    load_cc        = 1'b1;
                end
                s_ind_mar: begin
                    load_mar   = 1'b1;
                    marmux_sel = 2'b10;
                end
                s_st_mdr: begin
                    load_mdr     = 1'b1;
                    storemux_sel = 1'b1;
                    aluop        = alu_pass;
                end
                s_st_mem: begin
                    mem_write = 1'b1;
                    if (opcode == op_stb) mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
                end
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
                s_halt: begin
                    mem_byte_enable = 2'b00;
                    mem_error       = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Testbench for cpu_control: table of instructions with expected cycle
// counts, memory strobe counts, PC loads and one key-cycle output snapshot,
// checked through a scoreboard queue; plus reset and timeout sequences.
module tb_cpu_control;
    import lc3b_types::*;

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
        logic [1:0] pcmux, alumux, regfilemux, marmux, loadmux;
        logic       storemux, mdrmux, pcoffsetmux, maradjmux;
        lc3b_aluop  aluop;
        logic       mem_read, mem_write;
        logic [1:0] be;
        logic       mem_error;
    } ctrl_t;

    typedef struct {
        string      name;
        lc3b_opcode op;
        logic [5:0] flags;   // {imm5, br_en, off11, d_bit, a_bit, mar_lsb}
        int         delay;   // extra wait cycles before each mem_resp
        int         cycles;  // FETCH1 .. last state before the next FETCH1
        int         reads;
        int         writes;
        int         pc_loads;
        int         key_idx;
        ctrl_t      key_exp;
        logic [1:0] be_or;   // OR of mem_byte_enable over write cycles
    } vec_t;

    logic       clk, rst_n;
    lc3b_opcode opcode;
    logic       branch_enable, imm5_enable, offset11_enable, d_bit, a_bit, mar_lsb, mem_resp;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel, loadmux_sel;
    logic       storemux_sel, mdrmux_sel, pcoffsetmux_sel, maradjmux_sel;
    lc3b_aluop  aluop;
    logic       mem_read, mem_write, mem_error;
    logic [1:0] mem_byte_enable;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    resp_delay = 0;
    int    wait_cnt = 0;
    bit    resp_en = 1'b1;
    vec_t  vecs[$];
    vec_t  sb_q[$];
    ctrl_t cur;

    cpu_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .branch_enable(branch_enable), .imm5_enable(imm5_enable),
        .offset11_enable(offset11_enable), .d_bit(d_bit), .a_bit(a_bit),
        .mar_lsb(mar_lsb), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
        .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
        .marmux_sel(marmux_sel), .loadmux_sel(loadmux_sel), .storemux_sel(storemux_sel),
        .mdrmux_sel(mdrmux_sel), .pcoffsetmux_sel(pcoffsetmux_sel),
        .maradjmux_sel(maradjmux_sel), .aluop(aluop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_error(mem_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb_cpu_control hung");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic ctrl_t snap();
        ctrl_t c;
        c.load_pc = load_pc;           c.load_ir = load_ir;
        c.load_regfile = load_regfile; c.load_mar = load_mar;
        c.load_mdr = load_mdr;         c.load_cc = load_cc;
        c.pcmux = pcmux_sel;           c.alumux = alumux_sel;
        c.regfilemux = regfilemux_sel; c.marmux = marmux_sel;
        c.loadmux = loadmux_sel;       c.storemux = storemux_sel;
        c.mdrmux = mdrmux_sel;         c.pcoffsetmux = pcoffsetmux_sel;
        c.maradjmux = maradjmux_sel;   c.aluop = aluop;
        c.mem_read = mem_read;         c.mem_write = mem_write;
        c.be = mem_byte_enable;        c.mem_error = mem_error;
        return c;
    endfunction

    function automatic ctrl_t idle();
        ctrl_t c;
        c = '0;
        c.be = 2'b11;
        return c;
    endfunction

    function automatic bit is_fetch1(input ctrl_t c);
        return c.load_pc && c.load_mar && (c.marmux == 2'b01) && (c.pcmux == 2'b00);
    endfunction

    // Memory model: answers after resp_delay wait cycles of a request.
    task automatic respond(input ctrl_t s);
        if ((s.mem_read || s.mem_write) && resp_en) begin
            mem_resp = (wait_cnt >= resp_delay);
            wait_cnt++;
        end else begin
            mem_resp = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic add_vec(input string name, input lc3b_opcode op, input logic [5:0] flags,
                           input int delay, input int cycles, input int reads, input int writes,
                           input int pc_loads, input int key_idx, input ctrl_t key_exp,
                           input logic [1:0] be_or);
        vec_t v;
        v.name = name; v.op = op; v.flags = flags; v.delay = delay;
        v.cycles = cycles; v.reads = reads; v.writes = writes; v.pc_loads = pc_loads;
        v.key_idx = key_idx; v.key_exp = key_exp; v.be_or = be_or;
        vecs.push_back(v);
    endtask

    // Runs one instruction starting from the FETCH1 cycle already held in cur.
    task automatic run_instr(input vec_t v);
        vec_t       e;
        ctrl_t      s, key_act;
        int         idx, reads, writes, pcl;
        logic [1:0] be_or;
        bit         done;
        opcode = v.op;
        {imm5_enable, branch_enable, offset11_enable, d_bit, a_bit, mar_lsb} = v.flags;
        resp_delay = v.delay;
        sb_q.push_back(v);
        s = cur; idx = 0; reads = 0; writes = 0; pcl = 0; be_or = 2'b00;
        key_act = '1; done = 1'b0;
        while (idx < 64) begin
            if (idx == v.key_idx) key_act = s;
            reads  += int'(s.mem_read);
            writes += int'(s.mem_write);
            pcl    += int'(s.load_pc);
            if (s.mem_write) be_or |= s.be;
            respond(s);
            @(negedge clk);
            s = snap();
            idx++;
            if (is_fetch1(s)) begin
                done = 1'b1;
                break;
            end
        end
        cur = s;
        e = sb_q.pop_front();
        check({e.name, ".finished"}, 32'(done), 32'd1);
        check({e.name, ".cycles"},   32'(idx), 32'(e.cycles));
        check({e.name, ".reads"},    32'(reads), 32'(e.reads));
        check({e.name, ".writes"},   32'(writes), 32'(e.writes));
        check({e.name, ".pc_loads"}, 32'(pcl), 32'(e.pc_loads));
        check({e.name, ".key"},      32'(key_act), 32'(e.key_exp));
        check({e.name, ".be_or"},    32'(be_or), 32'(e.be_or));
    endtask

    initial begin
        ctrl_t k, s, f1, f2, halt_v;
        int    reads;

        f1 = idle(); f1.load_pc = 1; f1.load_mar = 1; f1.marmux = 2'b01;
        f2 = idle(); f2.mem_read = 1; f2.load_mdr = 1; f2.mdrmux = 1;
        halt_v = '0; halt_v.mem_error = 1;

        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.alumux = 2'b10;
        add_vec("add_imm", op_add, 6'b100000, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.aluop = alu_and;
        add_vec("and_reg", op_and, 6'b000000, 1, 6, 2, 0, 1, 5, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.aluop = alu_not;
        add_vec("not", op_not, 6'b000000, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.alumux = 2'b11; k.aluop = alu_sll;
        add_vec("shf_sll", op_shf, 6'b000000, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k.aluop = alu_srl;
        add_vec("shf_srl", op_shf, 6'b000100, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k.aluop = alu_sra;
        add_vec("shf_sra", op_shf, 6'b000110, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k = idle();
        add_vec("br_not_taken", op_br, 6'b000000, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k = idle(); k.load_pc = 1; k.pcmux = 2'b01;
        add_vec("br_taken", op_br, 6'b010000, 2, 8, 3, 0, 2, 7, k, 2'b00);
        k = idle(); k.load_pc = 1; k.pcmux = 2'b10;
        add_vec("jmp", op_jmp, 6'b000000, 0, 5, 1, 0, 2, 4, k, 2'b00);
        k = idle(); k.load_pc = 1; k.pcmux = 2'b01; k.pcoffsetmux = 1;
        add_vec("jsr_off11", op_jsr, 6'b001000, 0, 6, 1, 0, 2, 5, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.regfilemux = 2'b11;
        add_vec("jsr_r7", op_jsr, 6'b000000, 0, 6, 1, 0, 2, 4, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.regfilemux = 2'b10; k.loadmux = 2'b10;
        add_vec("lea", op_lea, 6'b000000, 0, 5, 1, 0, 1, 4, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.regfilemux = 2'b01;
        add_vec("ldr_wb", op_ldr, 6'b000000, 1, 9, 4, 0, 1, 8, k, 2'b00);
        k = idle(); k.load_mar = 1; k.alumux = 2'b01;
        add_vec("str_calc", op_str, 6'b000000, 0, 7, 1, 1, 1, 4, k, 2'b11);
        k = idle(); k.load_mar = 1; k.marmux = 2'b11; k.maradjmux = 1;
        add_vec("ldb_calc", op_ldb, 6'b000000, 0, 7, 2, 0, 1, 4, k, 2'b00);
        k = idle(); k.load_regfile = 1; k.load_cc = 1; k.regfilemux = 2'b10; k.loadmux = 2'b01;
        add_vec("ldb_wb_hi", op_ldb, 6'b000001, 0, 7, 2, 0, 1, 6, k, 2'b00);
        k = idle(); k.mem_write = 1; k.be = 2'b10;
        add_vec("stb_hi_wait", op_stb, 6'b000001, 3, 13, 4, 4, 1, 9, k, 2'b10);
        k = idle(); k.load_mdr = 1; k.storemux = 1; k.aluop = alu_pass;
        add_vec("stb_lo_mdr", op_stb, 6'b000000, 0, 7, 1, 1, 1, 5, k, 2'b01);
        k = idle(); k.load_mar = 1; k.marmux = 2'b10;
        add_vec("ldi_ind_mar", op_ldi, 6'b000000, 0, 9, 3, 0, 1, 6, k, 2'b00);
        add_vec("sti_ind_mem", op_sti, 6'b000000, 1, 12, 4, 2, 1, 6, f2, 2'b11);
        k = idle();
        add_vec("trap_decode", op_trap, 6'b000000, 0, 4, 1, 0, 1, 3, k, 2'b00);
        k = idle(); k.load_ir = 1;
        add_vec("rti_fetch3", op_rti, 6'b000000, 0, 4, 1, 0, 1, 2, k, 2'b00);
        add_vec("add_fetch2", op_add, 6'b000000, 0, 5, 1, 0, 1, 1, f2, 2'b00);

        // Reset state
        rst_n = 1'b0; mem_resp = 1'b0; opcode = op_br;
        {imm5_enable, branch_enable, offset11_enable, d_bit, a_bit, mar_lsb} = 6'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(snap()), 32'(idle()));
        rst_n = 1'b1;
        #1 cur = snap();
        check("post_reset_fetch1", 32'(cur), 32'(f1));

        foreach (vecs[i]) run_instr(vecs[i]);

        // Reset in the middle of LD_MEM: strobe drops at once, restart at FETCH1
        opcode = op_ldr; resp_delay = 0; resp_en = 1'b1;
        {imm5_enable, branch_enable, offset11_enable, d_bit, a_bit, mar_lsb} = 6'b0;
        s = cur;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) resp_en = 1'b0;
            respond(s);
            @(negedge clk);
            s = snap();
        end
        check("ld_mem_reading", 32'(s.mem_read), 32'd1);
        rst_n = 1'b0;
        #1 s = snap();
        check("ld_mem_reset_read", 32'(s.mem_read), 32'd0);
        check("ld_mem_reset_outputs", 32'(s), 32'(idle()));
        mem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("restart_fetch1", 32'(snap()), 32'(f1));
        @(negedge clk);
        check("restart_fetch2", 32'(snap()), 32'(f2));

        // Memory never answers
        rst_n = 1'b0; resp_en = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reads = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s = snap();
            reads += int'(s.mem_read);
        end
`ifdef CPU_CONTROL_MEM_TIMEOUT_EN
        check("timeout_wait_cycles", 32'(reads), 32'd4);
        check("halt_entered", 32'(s), 32'(halt_v));
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("halt_sticky", 32'(snap()), 32'(halt_v));
        rst_n = 1'b0;
        #1 check("halt_cleared_by_reset", 32'(snap()), 32'(idle()));
`else
        check("unbounded_wait_cycles", 32'(reads), 32'd5);
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("still_waiting", 32'(snap()), 32'(f2));
        rst_n = 1'b0;
        #1 check("wait_reset", 32'(snap()), 32'(idle()));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
